// File: rtl/amber_wb_mem_responder.sv
// Wishbone slave memory for the Amber 128-bit bus, with programmable wait states and a preload port.
// Optional WB_RESP_ERR_EN: out-of-range addresses get o_wb_err instead of wrapping.
module amber_wb_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [31:0]              i_wb_adr,
  input  logic [15:0]              i_wb_sel,
  input  logic                     i_wb_we,
  input  logic [127:0]             i_wb_dat,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic [127:0]             o_wb_dat,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  input  logic                     i_ld_we,
  input  logic [$clog2(DEPTH)-1:0] i_ld_idx,
  input  logic [127:0]             i_ld_dat,
  output logic                     o_busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DAT_W = 128;
  localparam int unsigned SEL_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_we;
  logic [SEL_W-1:0]   lat_sel;
  logic [DAT_W-1:0]   lat_dat;
  logic               lat_ok;

  logic [DAT_W-1:0]   mem [DEPTH];

  logic [31:0]        off_c;
  logic [IDX_W-1:0]   idx_c;
  logic               range_ok_c;
  logic               req_c;
  logic               go_resp_c;
  logic [IDX_W-1:0]   rsp_idx_c;
  logic               rsp_we_c;
  logic [SEL_W-1:0]   rsp_sel_c;
  logic [DAT_W-1:0]   rsp_dat_c;
  logic               rsp_ok_c;
  logic               unused_ok;

  assign off_c = i_wb_adr - BASE_ADDR;
  assign idx_c = off_c[IDX_W+3:4];
  assign req_c = i_wb_cyc & i_wb_stb;

`ifdef WB_RESP_ERR_EN
  assign range_ok_c = (i_wb_adr >= BASE_ADDR) && (off_c[31:IDX_W+4] == '0);
`else
  assign range_ok_c = 1'b1;
`endif

  // Offset bits below the word and above the index only matter for the range check.
  assign unused_ok = &{1'b0, off_c[3:0], off_c[31:IDX_W+4]};

  // Zero wait states respond straight from the bus; otherwise from the latched request.
  always_comb begin
    rsp_idx_c = lat_idx;
    rsp_we_c  = lat_we;
    rsp_sel_c = lat_sel;
    rsp_dat_c = lat_dat;
    rsp_ok_c  = lat_ok;
    if (state == S_IDLE) begin
      rsp_idx_c = idx_c;
      rsp_we_c  = i_wb_we;
      rsp_sel_c = i_wb_sel;
      rsp_dat_c = i_wb_dat;
      rsp_ok_c  = range_ok_c;
    end
  end

  // Entry into RESP; gated by reset so a request held during reset never writes.
  always_comb begin
    go_resp_c = 1'b0;
    if (i_rst_n) begin
      if ((state == S_IDLE) && req_c && (WAIT_STATES == 0))
        go_resp_c = 1'b1;
      else if ((state == S_WAIT) && i_wb_cyc && (cnt == CNT_W'(1)))
        go_resp_c = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lat_idx  <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      lat_dat  <= '0;
      lat_ok   <= 1'b0;
      o_wb_dat <= '0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            lat_idx <= idx_c;
            lat_we  <= i_wb_we;
            lat_sel <= i_wb_sel;
            lat_dat <= i_wb_dat;
            lat_ok  <= range_ok_c;
            cnt     <= CNT_W'(WAIT_STATES);
            if (WAIT_STATES > 0) begin
              state  <= S_WAIT;
              o_busy <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!i_wb_cyc) begin
            state  <= S_IDLE;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
      if (go_resp_c) begin
        state    <= S_RESP;
        o_busy   <= 1'b1;
        o_wb_ack <= rsp_ok_c;
        o_wb_err <= ~rsp_ok_c;
        if (rsp_ok_c && !rsp_we_c)
          o_wb_dat <= mem[rsp_idx_c];
      end
    end
  end

  // Byte-enabled bus write, then preload; the later assignment wins on a same-word collision.
  always_ff @(posedge i_clk) begin
    if (go_resp_c && rsp_we_c && rsp_ok_c) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (rsp_sel_c[b])
          mem[rsp_idx_c][8*b +: 8] <= rsp_dat_c[8*b +: 8];
      end
    end
    if (i_ld_we)
      mem[i_ld_idx] <= i_ld_dat;
  end

endmodule
